// File: rtl/hue_pkg.sv
// Shared types and helpers for the hue_sweep colour-wheel sequencer.
// The hue sector is the sequencer's FSM state and is exported on the sector output.
package hue_pkg;

  typedef enum logic [2:0] {
    SEC_RG = 3'd0,
    SEC_GR = 3'd1,
    SEC_GB = 3'd2,
    SEC_BG = 3'd3,
    SEC_BR = 3'd4,
    SEC_RB = 3'd5
  } sector_t;

  // Duty units per ramp level.
  function automatic int hue_step(input int pwm_interval, input int inc_dec_max);
    return pwm_interval / inc_dec_max;
  endfunction

  function automatic int level_to_duty(input int level, input int step);
    return level * step;
  endfunction

  // Floor-rounded square-law duty, evaluated only at elaboration time.
  function automatic int gamma_duty(input int level, input int pwm_interval, input int inc_dec_max);
    return (level * level * pwm_interval) / (inc_dec_max * inc_dec_max);
  endfunction

endpackage

// File: rtl/hue_sweep_if.sv
// Control and duty-output bundle between the hue sequencer and its controller / PWM stages.
interface hue_sweep_if #(
  parameter int W = 11
);
  // No valid/ready handshake: enable and restart are level controls sampled every clock,
  // and the duty/sector/wrap outputs are registered and valid every cycle after reset.
  logic         enable;
  logic         restart;
  logic [W-1:0] pwm_valueR;
  logic [W-1:0] pwm_valueG;
  logic [W-1:0] pwm_valueB;
  logic [2:0]   sector;
  logic         wrap;

  modport master (
    output enable, restart,
    input  pwm_valueR, pwm_valueG, pwm_valueB, sector, wrap
  );

  modport slave (
    input  enable, restart,
    output pwm_valueR, pwm_valueG, pwm_valueB, sector, wrap
  );
endinterface

// File: rtl/hue_gamma_lut.sv
// Gamma table of INC_DEC_MAX+1 floor-rounded entries with one registered read port.
// Used by hue_sweep only when HUE_SWEEP_GAMMA_EN is defined.
module hue_gamma_lut
  import hue_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int INC_DEC_MAX  = 200,
  parameter int RST_LEVEL    = 0,
  parameter int W            = 11,
  parameter int LW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] level_i,
  output logic [W-1:0]  duty_o
);

  logic [W-1:0] rom [INC_DEC_MAX+1];
  logic [W-1:0] duty_q;

  for (genvar i = 0; i <= INC_DEC_MAX; i++) begin : g_rom
    assign rom[i] = W'(gamma_duty(i, PWM_INTERVAL, INC_DEC_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= W'(gamma_duty(RST_LEVEL, PWM_INTERVAL, INC_DEC_MAX));
    end else if (int'(level_i) > INC_DEC_MAX) begin
      duty_q <= '0;
    end else begin
      duty_q <= rom[level_i];
    end
  end

  assign duty_o = duty_q;

endmodule

// File: rtl/hue_sweep.sv
// Six-sector RGB colour-wheel sequencer feeding three PWM stages with coherent duty values.
// Optional feature macro: HUE_SWEEP_GAMMA_EN (square-law duty via table, one extra cycle latency).
module hue_sweep
  import hue_pkg::*;
#(
  parameter int PWM_INTERVAL     = 1200,
  parameter int INC_DEC_INTERVAL = 12000,
  parameter int INC_DEC_MAX      = 200
) (
  input  logic       clk,
  input  logic       rst,
  hue_sweep_if.slave bus
);

  localparam int W  = $clog2(PWM_INTERVAL);
  localparam int TW = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
  localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;
  localparam int LW = $clog2(INC_DEC_MAX + 1);
  localparam logic [LW-1:0] FULL = LW'(INC_DEC_MAX);

  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] step_q, step_d;
  sector_t       sector_q, sector_d;
  logic          tick;
  logic          wrap_d;
  logic [LW-1:0] ramp;
  logic [LW-1:0] lvl_r_d, lvl_g_d, lvl_b_d;

  assign tick = bus.enable && (timer_q == TW'(INC_DEC_INTERVAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      step_q   <= '0;
      sector_q <= SEC_RG;
    end else begin
      timer_q  <= timer_d;
      step_q   <= step_d;
      sector_q <= sector_d;
    end
  end

  always_comb begin : next_state
    timer_d  = timer_q;
    step_d   = step_q;
    sector_d = sector_q;
    wrap_d   = 1'b0;
    if (bus.restart) begin
      timer_d  = '0;
      step_d   = '0;
      sector_d = SEC_RG;
    end else begin
      if (bus.enable) begin
        timer_d = tick ? '0 : timer_q + TW'(1);
      end
      if (tick) begin
        if (step_q == SW'(INC_DEC_MAX - 1)) begin
          step_d = '0;
          case (sector_q)
            SEC_RG:  sector_d = SEC_GR;
            SEC_GR:  sector_d = SEC_GB;
            SEC_GB:  sector_d = SEC_BG;
            SEC_BG:  sector_d = SEC_BR;
            SEC_BR:  sector_d = SEC_RB;
            SEC_RB: begin
              sector_d = SEC_RG;
              wrap_d   = 1'b1;
            end
            default: sector_d = SEC_RG;
          endcase
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      // Encodings 6 and 7 are never produced; recover on the next edge regardless of enable.
      if (sector_q > SEC_RB) begin
        sector_d = SEC_RG;
        wrap_d   = 1'b0;
      end
    end
  end

  // Levels are derived from next-state step/sector so the registered outputs move on the same edge.
  always_comb begin : levels
    ramp    = LW'(step_d);
    lvl_r_d = FULL;
    lvl_g_d = '0;
    lvl_b_d = '0;
    case (sector_d)
      SEC_RG: begin lvl_r_d = FULL;        lvl_g_d = ramp;        lvl_b_d = '0;          end
      SEC_GR: begin lvl_r_d = FULL - ramp; lvl_g_d = FULL;        lvl_b_d = '0;          end
      SEC_GB: begin lvl_r_d = '0;          lvl_g_d = FULL;        lvl_b_d = ramp;        end
      SEC_BG: begin lvl_r_d = '0;          lvl_g_d = FULL - ramp; lvl_b_d = FULL;        end
      SEC_BR: begin lvl_r_d = ramp;        lvl_g_d = '0;          lvl_b_d = FULL;        end
      SEC_RB: begin lvl_r_d = FULL;        lvl_g_d = '0;          lvl_b_d = FULL - ramp; end
      default: ;
    endcase
  end

  assign bus.sector = sector_q;

`ifdef HUE_SWEEP_GAMMA_EN
  logic [LW-1:0] lvl_r_q, lvl_g_q, lvl_b_q;
  logic          wrap_q, wrap_qq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_r_q <= FULL;
      lvl_g_q <= '0;
      lvl_b_q <= '0;
      wrap_q  <= 1'b0;
      wrap_qq <= 1'b0;
    end else begin
      lvl_r_q <= lvl_r_d;
      lvl_g_q <= lvl_g_d;
      lvl_b_q <= lvl_b_d;
      wrap_q  <= wrap_d;
      wrap_qq <= wrap_q;
    end
  end

  hue_gamma_lut #(.PWM_INTERVAL(PWM_INTERVAL), .INC_DEC_MAX(INC_DEC_MAX),
                  .RST_LEVEL(INC_DEC_MAX), .W(W), .LW(LW))
    u_lut_r (.clk(clk), .rst(rst), .level_i(lvl_r_q), .duty_o(bus.pwm_valueR));
  hue_gamma_lut #(.PWM_INTERVAL(PWM_INTERVAL), .INC_DEC_MAX(INC_DEC_MAX),
                  .RST_LEVEL(0), .W(W), .LW(LW))
    u_lut_g (.clk(clk), .rst(rst), .level_i(lvl_g_q), .duty_o(bus.pwm_valueG));
  hue_gamma_lut #(.PWM_INTERVAL(PWM_INTERVAL), .INC_DEC_MAX(INC_DEC_MAX),
                  .RST_LEVEL(0), .W(W), .LW(LW))
    u_lut_b (.clk(clk), .rst(rst), .level_i(lvl_b_q), .duty_o(bus.pwm_valueB));

  assign bus.wrap = wrap_qq;
`else
  localparam int STEP = hue_step(PWM_INTERVAL, INC_DEC_MAX);

  logic [W-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic         wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r_q <= W'(PWM_INTERVAL);
      duty_g_q <= '0;
      duty_b_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      duty_r_q <= W'(level_to_duty(int'(lvl_r_d), STEP));
      duty_g_q <= W'(level_to_duty(int'(lvl_g_d), STEP));
      duty_b_q <= W'(level_to_duty(int'(lvl_b_d), STEP));
      wrap_q   <= wrap_d;
    end
  end

  assign bus.pwm_valueR = duty_r_q;
  assign bus.pwm_valueG = duty_g_q;
  assign bus.pwm_valueB = duty_b_q;
  assign bus.wrap       = wrap_q;
`endif

endmodule
